sync_debounce: RTL and testbench

- Downstream consumer of the two-flop synchronizer: takes its already-synchronized single-bit output and produces a debounced level plus one-cycle rise/fall event pulses.
- Filters bounce and glitches with a stability counter: the output follows the input only after the input has held a new value for STABLE_CYCLES consecutive clocks.
- Sits between the synchronizer and control logic such as button, strap or handshake-line handlers.

---
 rtl/sync_debounce.sv | 143 ++++++++++++++
 tb/tb_sync_debounce.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// sync_debounce
//   Debounces an already-synchronized single-bit input. The output follows
//   the input only after the input has differed from the output for
//   STABLE_CYCLES consecutive rising edges. Every change of the output
//   comes with a one-cycle rise or fall pulse.
//
// Ports
//   CLK        in   clock; all state updates on the rising edge
//   RST        in   synchronous reset, active-high
//   in         in   synchronized input bit
//   out        out  debounced level (INIT_LEVEL after reset)
//   rise       out  one-cycle pulse when out goes 0->1
//   fall       out  one-cycle pulse when out goes 1->0
//   busy       out  high while a candidate change is pending
//   glitch_cnt out  saturating count of aborted transitions (optional)
//
// Optional feature
//   SYNC_DEBOUNCE_GLITCH_CNT_EN: when defined, adds the glitch_cnt port and
//   its diagnostic counter. When undefined, neither the port nor the
//   counter exists, and all other behaviour is unchanged.
module sync_debounce #(
  parameter int   CNT_WIDTH     = 16,
  parameter int   STABLE_CYCLES = 1000,
  parameter logic INIT_LEVEL    = 1'b0,
  parameter int   GLITCH_WIDTH  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in,
  output logic                    out,
  output logic                    rise,
  output logic                    fall,
  output logic                    busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_WIDTH-1:0] glitch_cnt
`endif
);

  // Reject parameter sets the counter cannot represent.
  if (STABLE_CYCLES < 1) begin : g_bad_stable_min
    $error("sync_debounce: STABLE_CYCLES must be >= 1");
  end
  if (64'(STABLE_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_stable_max
    $error("sync_debounce: STABLE_CYCLES must be < 2**CNT_WIDTH");
  end
  if (GLITCH_WIDTH < 1) begin : g_bad_glitch_w
    $error("sync_debounce: GLITCH_WIDTH must be >= 1");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 out_nxt, rise_nxt, fall_nxt;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  function automatic logic [GLITCH_WIDTH-1:0] sat_inc(input logic [GLITCH_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE: begin
        if (in != out) begin
          if (STABLE_CYCLES == 1) begin
            // A single differing sample is already enough: flip now.
            out_nxt  = in;
            rise_nxt = in;
            fall_nxt = ~in;
          end else begin
            state_nxt = PEND;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      PEND: begin
        if (in == out) begin
          // Input bounced back before qualifying; drop the candidate.
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          // This edge is the STABLE_CYCLES-th differing sample.
          out_nxt   = in;
          rise_nxt  = in;
          fall_nxt  = ~in;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= STABLE;
      cnt   <= '0;
      out   <= INIT_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      glitch_cnt <= '0;
    end else if (state == PEND && in == out) begin
      glitch_cnt <= sat_inc(glitch_cnt);
    end
  end
`endif

  // busy is a decode of the state register, so it stays free of any path from in.
  assign busy = (state == PEND);

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce
//   Drives two instances of sync_debounce (STABLE_CYCLES=4 and
//   STABLE_CYCLES=1) with directed sequences followed by random stimulus,
//   and compares every output after every edge against a behavioural model
//   that tracks how many consecutive edges the input has differed from the
//   debounced level.
module tb_sync_debounce;

  localparam int GW = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST = 1'b1;
  logic in4 = 1'b0;
  logic in1 = 1'b0;

  logic out4, rise4, fall4, busy4;
  logic out1, rise1, fall1, busy1;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [GW-1:0] glitch4, glitch1;
`endif

  sync_debounce #(
    .CNT_WIDTH(16), .STABLE_CYCLES(4), .INIT_LEVEL(1'b0), .GLITCH_WIDTH(GW)
  ) dut4 (
    .CLK(CLK), .RST(RST), .in(in4), .out(out4), .rise(rise4), .fall(fall4), .busy(busy4)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch4)
`endif
  );

  sync_debounce #(
    .CNT_WIDTH(4), .STABLE_CYCLES(1), .INIT_LEVEL(1'b0), .GLITCH_WIDTH(GW)
  ) dut1 (
    .CLK(CLK), .RST(RST), .in(in1), .out(out1), .rise(rise1), .fall(fall1), .busy(busy1)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch1)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state, index 0 -> dut4, index 1 -> dut1.
  int   m_need [2] = '{4, 1};
  logic m_out  [2];
  logic m_rise [2];
  logic m_fall [2];
  int   m_run  [2];
  int   m_gl   [2];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic x;
      x = (i == 0) ? in4 : in1;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (RST) begin
        m_out[i] = 1'b0;
        m_run[i] = 0;
        m_gl[i]  = 0;
      end else if (x != m_out[i]) begin
        m_run[i]++;
        if (m_run[i] == m_need[i]) begin
          m_out[i]  = x;
          m_rise[i] = x;
          m_fall[i] = ~x;
          m_run[i]  = 0;
        end
      end else begin
        if (m_run[i] > 0 && m_gl[i] < (1 << GW) - 1) m_gl[i]++;
        m_run[i] = 0;
      end
    end
  endtask

  task automatic compare();
    chk("out4", out4, m_out[0]);
    chk("rise4", rise4, m_rise[0]);
    chk("fall4", fall4, m_fall[0]);
    chk("busy4", busy4, (m_run[0] > 0) ? 1 : 0);
    chk("excl4", rise4 & fall4, 0);
    chk("out1", out1, m_out[1]);
    chk("rise1", rise1, m_rise[1]);
    chk("fall1", fall1, m_fall[1]);
    chk("busy1", busy1, (m_run[1] > 0) ? 1 : 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch4", glitch4, m_gl[0]);
    chk("glitch1", glitch1, m_gl[1]);
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare();
  endtask

  // One edge with in4 set to v and in1 toggled.
  task automatic drive4(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      in4 = v;
      in1 = ~in1;
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0; m_gl[i] = 0;
    end

    // Reset then idle.
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    drive4(1'b0, 10);

    // Clean rise, then clean fall.
    drive4(1'b1, 6);
    drive4(1'b0, 6);

    // Bounce rejection repeated until the glitch counter saturates.
    for (int r = 0; r < 300; r++) begin
      drive4(1'b1, 3);
      drive4(1'b0, 1);
    end
    drive4(1'b0, 3);

    // Reset while a change is pending.
    drive4(1'b1, 2);
    RST = 1'b1;
    drive4(1'b1, 1);
    RST = 1'b0;
    drive4(1'b1, 3);
    drive4(1'b1, 3);

    // Random stimulus: in4 held for random run lengths, in1 fully random,
    // occasional single-cycle resets.
    for (int r = 0; r < 600; r++) begin
      logic v;
      int   len;
      v   = 1'($urandom);
      len = int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++) begin
        in4 = v;
        in1 = 1'($urandom);
        RST = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    RST = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
